// File: rtl/uart_pkg.sv
// Shared UART framing definitions: FSM state encoding, parity modes and
// default frame geometry. Imported by both the transmitter and receiver so
// both ends of the link agree on framing.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned DEFAULT_WORD_SIZE  = 8;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    // Parity bit for a data word. Callers zero-extend the word to 32 bits,
    // which leaves the XOR reduction unchanged.
    function automatic logic parity_bit(input logic [31:0] data, input int unsigned mode);
        logic p;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between an upstream producer and the UART transmitter.
// A byte moves on a rising edge where t_valid && t_ready.
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE
);

    logic                 t_valid;
    logic [WORD_SIZE-1:0] t_byte;
    logic                 t_ready;

    modport master (
        output t_valid,
        output t_byte,
        input  t_ready
    );

    modport slave (
        input  t_valid,
        input  t_byte,
        output t_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Clock divider producing one oversample tick every CLK_DIV cycles.
// A synchronous restart realigns the tick phase to a frame start.
module uart_baud_tick #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap at CLK_DIV-1, or return to zero on restart.
    always_comb begin
        if (restart_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts bytes over a valid/ready handshake into a
// one-entry holding register and shifts them out LSB-first as
// start / data / optional parity / stop bits. A full holding register at
// the end of a stop bit starts the next frame with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY     = PAR_NONE
) (
    input  logic     t_clk,
    input  logic     t_rst,
    uart_tx_if.slave bus,
    output logic     serial_o,
    output logic     busy,
    output logic     done
);

    localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned IDX_W = $clog2(WORD_SIZE + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(WORD_SIZE - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    uart_state_e          state_q,     state_d;
    logic [WORD_SIZE-1:0] shift_q,     shift_d;
    logic [WORD_SIZE-1:0] hold_q,      hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 par_q,       par_d;
    logic [CNT_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q,   bit_idx_d;
    logic                 serial_q,    serial_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;

    logic tick;
    logic bit_end;
    logic load;
    logic frame_end;

    uart_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk_i    (t_clk),
        .rst_ni   (t_rst),
        .restart_i(load),
        .tick_o   (tick)
    );

    assign bit_end = tick && (bit_cnt_q == BIT_LAST);

    // State register: FSM, datapath and registered outputs.
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            serial_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_q       <= par_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            serial_q    <= serial_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state: handshake capture, bit timing and frame sequencing.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_d       = par_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        load        = 1'b0;
        frame_end   = 1'b0;

        // Writes only happen while empty and loads only while full, so the
        // holding register is never written and read on the same edge.
        if (bus.t_valid && !hold_full_q) begin
            hold_d      = bus.t_byte;
            hold_full_d = 1'b1;
        end

        if ((state_q != ST_IDLE) && tick) begin
            bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == STOP_LAST) begin
                        frame_end = 1'b1;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d   = ST_IDLE;
                            bit_idx_d = '0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                bit_idx_d = '0;
            end
        endcase

        // Frame start: move the held byte into the shifter and restart timing.
        if (load) begin
            state_d     = ST_START;
            shift_d     = hold_q;
            par_d       = parity_bit(32'(hold_q), PARITY);
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
            bit_idx_d   = '0;
        end
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        case (state_d)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shift_d[0];
            ST_PARITY: serial_d = par_d;
            default:   serial_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = frame_end;
    end

    assign bus.t_ready = ~hold_full_q;
    assign serial_o    = serial_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx: four instances cover the default frame,
// even parity with two stop bits, odd parity and a clock divider of 3.
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_if #(.WORD_SIZE(8)) if_def ();
    uart_tx_if #(.WORD_SIZE(8)) if_pe ();
    uart_tx_if #(.WORD_SIZE(8)) if_po ();
    uart_tx_if #(.WORD_SIZE(8)) if_d3 ();

    logic [3:0] ser;
    logic [3:0] bsy;
    logic [3:0] dn;
    logic [3:0] rdy;

    assign rdy[0] = if_def.t_ready;
    assign rdy[1] = if_pe.t_ready;
    assign rdy[2] = if_po.t_ready;
    assign rdy[3] = if_d3.t_ready;

    uart_tx u_def (
        .t_clk(clk), .t_rst(rst_n), .bus(if_def),
        .serial_o(ser[0]), .busy(bsy[0]), .done(dn[0])
    );
    uart_tx #(.PARITY(1), .STOP_BITS(2)) u_pe (
        .t_clk(clk), .t_rst(rst_n), .bus(if_pe),
        .serial_o(ser[1]), .busy(bsy[1]), .done(dn[1])
    );
    uart_tx #(.PARITY(2)) u_po (
        .t_clk(clk), .t_rst(rst_n), .bus(if_po),
        .serial_o(ser[2]), .busy(bsy[2]), .done(dn[2])
    );
    uart_tx #(.CLK_DIV(3)) u_d3 (
        .t_clk(clk), .t_rst(rst_n), .bus(if_d3),
        .serial_o(ser[3]), .busy(bsy[3]), .done(dn[3])
    );

    int tests = 0;
    int fails = 0;

    logic ln_buf [0:1023];
    logic dn_buf [0:1023];
    logic rd_buf [0:1023];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic v, input logic [7:0] b);
        case (w)
            0: begin if_def.t_valid = v; if_def.t_byte = b; end
            1: begin if_pe.t_valid  = v; if_pe.t_byte  = b; end
            2: begin if_po.t_valid  = v; if_po.t_byte  = b; end
            default: begin if_d3.t_valid = v; if_d3.t_byte = b; end
        endcase
    endtask

    task automatic drop(input int w);
        case (w)
            0: if_def.t_valid = 1'b0;
            1: if_pe.t_valid  = 1'b0;
            2: if_po.t_valid  = 1'b0;
            default: if_d3.t_valid = 1'b0;
        endcase
    endtask

    // Record n cycles of line/done/ready; valid is withdrawn once the
    // holding register has taken the byte.
    task automatic capture(input int w, input int n);
        for (int i = 0; i < n; i++) begin
            ln_buf[i] = ser[w];
            dn_buf[i] = dn[w];
            rd_buf[i] = rdy[w];
            if (!rdy[w]) drop(w);
            step();
        end
    endtask

    // Receiver model: sample data bits at mid-bit from the captured line.
    function automatic logic [7:0] decode(input int base, input int blen);
        logic [7:0] d;
        for (int b = 0; b < 8; b++) d[b] = ln_buf[base + blen * (b + 1) + blen / 2];
        return d;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b1, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if ({ser[0], rdy[0], bsy[0], dn[0]} !== 4'b1100) begin
                fails++;
                $display("FAIL reset_hold cyc%0d: ser/rdy/busy/done=%b expected 1100", i, {ser[0], rdy[0], bsy[0], dn[0]});
            end
        end
        drive(0, 1'b0, 8'h00);
        step();
        rst_n = 1'b1;
        step();
        tests++;
        if ({ser[0], rdy[0], bsy[0], dn[0]} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_release: ser/rdy/busy/done=%b expected 1100", {ser[0], rdy[0], bsy[0], dn[0]});
        end
    endtask

    task automatic test_single();
        logic [9:0] exp;
        int bad;
        int first_done;
        int n_done;
        exp = {1'b1, 8'hA5, 1'b0};
        drive(0, 1'b1, 8'hA5);
        step();
        tests++;
        if (rdy[0] !== 1'b0 || ser[0] !== 1'b1) begin
            fails++;
            $display("FAIL single_accept: rdy=%b ser=%b expected rdy=0 ser=1", rdy[0], ser[0]);
        end
        drop(0);
        step();
        capture(0, 200);
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < 16; c++) if (ln_buf[b * 16 + c] !== exp[b]) bad++;
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL single_bit%0d: %0d samples differ, expected level %b", b, bad, exp[b]);
            end
        end
        first_done = -1;
        n_done = 0;
        for (int i = 0; i < 200; i++) if (dn_buf[i] === 1'b1) begin
            n_done++;
            if (first_done < 0) first_done = i;
        end
        tests++;
        if (first_done != 160 || n_done != 1) begin
            fails++;
            $display("FAIL single_done: first=%0d count=%0d expected first=160 count=1", first_done, n_done);
        end
        bad = 0;
        for (int i = 0; i < 200; i++) if (rd_buf[i] !== 1'b1) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL single_ready_low: %0d extra low cycles expected 0", bad);
        end
        tests++;
        if (bsy[0] !== 1'b0 || ser[0] !== 1'b1) begin
            fails++;
            $display("FAIL single_idle_after: busy=%b ser=%b expected busy=0 ser=1", bsy[0], ser[0]);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [7:0] d0;
        logic [7:0] d1;
        drive(0, 1'b1, 8'h00);
        step();
        drive(0, 1'b1, 8'hFF);
        step();
        capture(0, 340);
        bad = 0;
        for (int i = 1; i < 160; i++) if (rd_buf[i] !== 1'b0) bad++;
        tests++;
        if (rd_buf[0] !== 1'b1 || bad != 0 || rd_buf[160] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready: rd[0]=%b highs_in_hold=%0d rd[160]=%b expected 1,0,1", rd_buf[0], bad, rd_buf[160]);
        end
        tests++;
        if (ln_buf[159] !== 1'b1 || ln_buf[160] !== 1'b0 || dn_buf[160] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_no_gap: ln159=%b ln160=%b done160=%b expected 1,0,1", ln_buf[159], ln_buf[160], dn_buf[160]);
        end
        tests++;
        if (dn_buf[320] !== 1'b1 || ln_buf[320] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_done: done320=%b ln320=%b expected 1,1", dn_buf[320], ln_buf[320]);
        end
        d0 = decode(0, 16);
        d1 = decode(160, 16);
        tests++;
        if (d0 !== 8'h00 || d1 !== 8'hFF || ln_buf[8] !== 1'b0 || ln_buf[168] !== 1'b0
            || ln_buf[152] !== 1'b1 || ln_buf[312] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_loopback: got %h %h expected 00 ff", d0, d1);
        end
    endtask

    task automatic test_parity();
        int bad;
        logic [7:0] d;
        drive(1, 1'b1, 8'h07);
        step();
        step();
        capture(1, 400);
        tests++;
        if (ln_buf[152] !== 1'b1 || ln_buf[192 + 152] !== 1'b1) begin
            fails++;
            $display("FAIL even_parity: bits %b %b expected 1 1", ln_buf[152], ln_buf[344]);
        end
        bad = 0;
        for (int i = 160; i < 192; i++) if (ln_buf[i] !== 1'b1) bad++;
        tests++;
        if (bad != 0 || ln_buf[192] !== 1'b0 || dn_buf[192] !== 1'b1) begin
            fails++;
            $display("FAIL two_stop: low_in_stop=%0d ln192=%b done192=%b expected 0,0,1", bad, ln_buf[192], dn_buf[192]);
        end
        d = decode(0, 16);
        tests++;
        if (d !== 8'h07) begin
            fails++;
            $display("FAIL even_data: got %h expected 07", d);
        end
        drive(2, 1'b1, 8'h07);
        step();
        drop(2);
        step();
        capture(2, 170);
        bad = 0;
        for (int i = 144; i < 160; i++) if (ln_buf[i] !== 1'b0) bad++;
        tests++;
        if (bad != 0 || ln_buf[160] !== 1'b1 || dn_buf[160] !== 1'b0 || dn_buf[176 - 1] === 1'b1) begin
            fails++;
            $display("FAIL odd_parity: parity_high_samples=%0d stop=%b expected 0,1", bad, ln_buf[160]);
        end
        tests++;
        if (dn_buf[159] !== 1'b0 || ser[2] !== 1'b1) begin
            fails++;
            $display("FAIL odd_frame_len: done159=%b ser=%b expected 0,1", dn_buf[159], ser[2]);
        end
    endtask

    task automatic test_clkdiv();
        logic [9:0] exp;
        int bad;
        int first_done;
        exp = {1'b1, 8'h81, 1'b0};
        drive(3, 1'b1, 8'h81);
        step();
        drop(3);
        step();
        capture(3, 500);
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < 48; c++) if (ln_buf[b * 48 + c] !== exp[b]) bad++;
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL div3_bit%0d: %0d samples differ, expected level %b", b, bad, exp[b]);
            end
        end
        first_done = -1;
        for (int i = 0; i < 500; i++) if (dn_buf[i] === 1'b1 && first_done < 0) first_done = i;
        tests++;
        if (first_done != 480) begin
            fails++;
            $display("FAIL div3_frame: done at %0d expected 480", first_done);
        end
    endtask

    task automatic test_reset_midframe();
        int bad;
        logic [7:0] d;
        drive(0, 1'b1, 8'h55);
        step();
        drive(0, 1'b1, 8'hAA);
        step();
        step();
        drop(0);
        tests++;
        if (rdy[0] !== 1'b0) begin
            fails++;
            $display("FAIL mid_held: rdy=%b expected 0", rdy[0]);
        end
        repeat (68) step();
        tests++;
        if (ser[0] !== 1'b0 || bsy[0] !== 1'b1) begin
            fails++;
            $display("FAIL mid_bit3: ser=%b busy=%b expected 0,1", ser[0], bsy[0]);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ser[0], rdy[0], bsy[0], dn[0]} !== 4'b1100) begin
            fails++;
            $display("FAIL mid_reset: ser/rdy/busy/done=%b expected 1100", {ser[0], rdy[0], bsy[0], dn[0]});
        end
        step();
        step();
        rst_n = 1'b1;
        capture(0, 200);
        bad = 0;
        for (int i = 0; i < 200; i++) if (dn_buf[i] !== 1'b0 || ln_buf[i] !== 1'b1 || rd_buf[i] !== 1'b1) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL mid_discard: %0d cycles with activity expected 0", bad);
        end
        drive(0, 1'b1, 8'h3C);
        step();
        drop(0);
        step();
        capture(0, 170);
        d = decode(0, 16);
        tests++;
        if (d !== 8'h3C || ln_buf[8] !== 1'b0 || ln_buf[152] !== 1'b1 || dn_buf[160] !== 1'b1) begin
            fails++;
            $display("FAIL mid_recover: got %h done160=%b expected 3c,1", d, dn_buf[160]);
        end
    endtask

    initial begin
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        drive(3, 1'b0, 8'h00);
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_clkdiv();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts parallel bytes over a valid/ready handshake and shifts each one out LSB-first on a single line as start bit, data bits, optional parity and stop bits. It sits directly upstream of the UART receiver on the serial link, so its bit timing uses the same 16x oversample tick. A one-entry holding register lets the next byte be accepted while the current frame is on the line, so frames go out back-to-back with no idle gap.

## Interface
- WORD_SIZE, 8: data bits per frame.
- OVERSAMPLE, 16: oversample ticks per bit period. Matches the receiver.
- CLK_DIV, 1: t_clk cycles per oversample tick, ≥1.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- PARITY, 0: 0 none, 1 even, 2 odd.
- t_clk  in  1  the single clock; all logic on its rising edge.
- t_rst  in  1  asynchronous, active-low reset.
- t_valid  in  1  upstream has a byte on t_byte.
- t_byte  in  WORD_SIZE  byte to send; sampled only on the accepting edge.
- t_ready  out  1  holding register empty; the byte is accepted when t_valid && t_ready at a rising edge.
- serial_o  out  1  serial line, registered, idles high.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse when a frame's final stop bit completes.

## Operation
- Reset values: serial_o=1, t_ready=1, busy=0, done=0, FSM in IDLE, holding register empty, counters 0.
- Tick generator: counts 0..CLK_DIV-1 and emits a tick at CLK_DIV-1. It restarts at 0 on every frame start.
- Bit counter: counts ticks 0..OVERSAMPLE-1. A bit ends on the tick where the count equals OVERSAMPLE-1.
- FSM states:
  - IDLE: if holding full, load the shift register, clear holding, go to START. Otherwise stay.
  - START: serial_o=0 for one bit, then go to DATA.
  - DATA: serial_o=shift[0]; shift right at each bit end. After WORD_SIZE bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY: serial_o = ^data for even, ~^data for odd. One bit, then STOP.
  - STOP: serial_o=1 for STOP_BITS bits. At the end, pulse done. If holding is full, load it and go directly to START (no gap); otherwise go to IDLE.
- Any illegal state encoding returns to IDLE with serial_o=1.
- t_ready = !hold_full. The holding register is never written and read on the same edge; ready-low backpressure is the only flow control.
- Reset asserted mid-frame: outputs go to reset values immediately (serial_o high). The in-flight and held bytes are discarded. No done pulse.

## Timing
- Accept at edge k: t_ready low after k. If the FSM is IDLE, the load happens at edge k+1: serial_o falls after k+1 and t_ready rises after k+1.
- Bit period: OVERSAMPLE*CLK_DIV cycles.
- Frame length: (1 + WORD_SIZE + (PARITY≠0) + STOP_BITS) × OVERSAMPLE × CLK_DIV cycles. Defaults give 160 cycles.
- done is high for the cycle following the last stop-bit tick, coincident with serial_o either staying high (IDLE) or falling (next START).
- All outputs are registered. There is no combinational path from t_valid or t_byte to any output.

## Structure
- Shared package uart_pkg holds:
  - state encoding: IDLE, START, DATA, PARITY, STOP;
  - parity mode constants: NONE=0, EVEN=1, ODD=2;
  - default WORD_SIZE and OVERSAMPLE.
- The package is shared with the receiver so both ends agree on framing.
- Sub-module uart_baud_tick: the CLK_DIV divider, with a synchronous restart input and a tick output. It is reusable by the receiver.

## Test plan
- Reset: hold t_rst low for 5 cycles with t_valid=1 -> serial_o=1, t_ready=1, busy=0, done=0 throughout; no accept.
- Single byte 0xA5, defaults -> serial_o is 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. done pulses exactly 160 cycles after serial_o falls. t_ready is low for exactly one cycle.
- Back-to-back 0x00 then 0xFF with t_valid held -> second start bit begins the cycle after the first stop bit (no idle). t_ready is low from the second accept until the second load. Loopback into the receiver returns 0x00, 0xFF.
- Parity with byte 0x07, PARITY=1 -> parity bit 1. With PARITY=2 -> 0. STOP_BITS=2 -> line high 32 cycles before the next start.
- CLK_DIV=3, byte 0x81 -> every bit lasts 48 cycles; frame is 480 cycles.
- t_rst pulsed low during data bit 3 of 0x55 with 0xAA held -> serial_o=1 immediately, t_ready=1, no done. The next accepted byte transmits cleanly.
